// File: rtl/ex_mem_pipe.sv
// EX->MEM pipeline register with a built-in sequencer for multi-cycle DIV/DIVU.
// Holds EX while a divide runs, captures the quotient and remainder, and recovers from a flushed divide.
module ex_mem_pipe (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid_i,
  input  logic [31:0] ex_pc_i,
  input  logic [31:0] ex_aluout_i,
  input  logic [4:0]  ex_waddr_i,
  input  logic        ex_we_i,
  input  logic [31:0] ex_rdata2_i,
  input  logic        ex_ov_i,
  input  logic [1:0]  ex_hilo_we_i,
  input  logic [31:0] ex_hi_i,
  input  logic [31:0] ex_lo_i,
  input  logic        ex_is_div_i,
  input  logic        ex_mult_stall_i,
  input  logic        div_ready_i,
  input  logic [31:0] div_hi_i,
  input  logic [31:0] div_lo_i,
  input  logic        mem_stall_i,
  input  logic        flush_i,
  output logic        div_start_o,
  output logic        ex_stall_o,
  output logic        mem_valid_o,
  output logic [31:0] mem_pc_o,
  output logic [31:0] mem_aluout_o,
  output logic [4:0]  mem_waddr_o,
  output logic        mem_we_o,
  output logic [31:0] mem_wdata_o,
  output logic        mem_ov_o,
  output logic [1:0]  mem_hilo_we_o,
  output logic [31:0] mem_hi_o,
  output logic [31:0] mem_lo_o
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE, S_ABORT} state_e;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] aluout;
    logic [4:0]  waddr;
    logic        we;
    logic [31:0] wdata;
    logic        ov;
    logic [1:0]  hilo_we;
    logic [31:0] hi;
    logic [31:0] lo;
  } mem_t;

  state_e      state_q, state_d;
  logic [31:0] hold_hi_q, hold_hi_d;
  logic [31:0] hold_lo_q, hold_lo_d;
  mem_t        mem_q, mem_d;

  logic ex_div;
  logic div_req;
  logic pipe_stall;

  assign ex_div  = ex_valid_i & ex_is_div_i;
  assign div_req = ex_div & ~flush_i;

  // Divide sequencer: pipe_stall is every EX hold that is not a downstream stall
  always_comb begin
    state_d     = state_q;
    hold_hi_d   = hold_hi_q;
    hold_lo_d   = hold_lo_q;
    div_start_o = 1'b0;
    pipe_stall  = ex_mult_stall_i;
    case (state_q)
      S_IDLE: begin
        div_start_o = div_req;
        pipe_stall  = ex_mult_stall_i | div_req;
        if (div_req) state_d = S_BUSY;
      end
      S_BUSY: begin
        pipe_stall = 1'b1;
        if (flush_i) begin
          // a ready arriving with the flush is already consumed, so nothing is left to drain
          state_d = div_ready_i ? S_IDLE : S_ABORT;
        end else if (div_ready_i) begin
          hold_hi_d = div_hi_i;
          hold_lo_d = div_lo_i;
          state_d   = S_DONE;
        end
      end
      S_DONE: begin
        if (flush_i || !mem_stall_i) state_d = S_IDLE;
      end
      S_ABORT: begin
        pipe_stall = ex_mult_stall_i | ex_div;
        if (div_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign ex_stall_o = mem_stall_i | pipe_stall;

  always_comb begin
    mem_d = mem_q;
    if (flush_i) begin
      mem_d = '0;
    end else if (mem_stall_i) begin
      mem_d = mem_q;
    end else if (pipe_stall || !ex_valid_i) begin
      mem_d = '0;
    end else begin
      mem_d.valid   = 1'b1;
      mem_d.pc      = ex_pc_i;
      mem_d.aluout  = ex_aluout_i;
      mem_d.waddr   = ex_waddr_i;
      mem_d.we      = ex_we_i;
      mem_d.wdata   = ex_rdata2_i;
      mem_d.ov      = ex_ov_i;
      mem_d.hilo_we = ex_hilo_we_i;
      mem_d.hi      = (state_q == S_DONE) ? hold_hi_q : ex_hi_i;
      mem_d.lo      = (state_q == S_DONE) ? hold_lo_q : ex_lo_i;
    end
  end

  // EX -> MEM stage boundary
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      hold_hi_q <= '0;
      hold_lo_q <= '0;
      mem_q     <= '0;
    end else begin
      state_q   <= state_d;
      hold_hi_q <= hold_hi_d;
      hold_lo_q <= hold_lo_d;
      mem_q     <= mem_d;
    end
  end

  assign mem_valid_o   = mem_q.valid;
  assign mem_pc_o      = mem_q.pc;
  assign mem_aluout_o  = mem_q.aluout;
  assign mem_waddr_o   = mem_q.waddr;
  assign mem_we_o      = mem_q.we;
  assign mem_wdata_o   = mem_q.wdata;
  assign mem_ov_o      = mem_q.ov;
  assign mem_hilo_we_o = mem_q.hilo_we;
  assign mem_hi_o      = mem_q.hi;
  assign mem_lo_o      = mem_q.lo;

endmodule

// File: tb/tb_ex_mem_pipe.sv
// Directed bench for ex_mem_pipe: pass-through, divide sequencing, stalls, flushes and async reset.
module tb_ex_mem_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_we, ex_ov, ex_is_div, ex_mult_stall;
  logic [31:0] ex_pc, ex_aluout, ex_rdata2, ex_hi, ex_lo;
  logic [4:0]  ex_waddr;
  logic [1:0]  ex_hilo_we;
  logic        div_ready, mem_stall, flush;
  logic [31:0] div_hi, div_lo;
  logic        div_start, ex_stall;
  logic        mem_valid, mem_we, mem_ov;
  logic [31:0] mem_pc, mem_aluout, mem_wdata, mem_hi, mem_lo;
  logic [4:0]  mem_waddr;
  logic [1:0]  mem_hilo_we;

  int n_cmp = 0;
  int n_err = 0;
  int starts, stalls, bubs;

  always #5 clk = ~clk;

  ex_mem_pipe dut (
    .clk(clk), .rst(rst),
    .ex_valid_i(ex_valid), .ex_pc_i(ex_pc), .ex_aluout_i(ex_aluout),
    .ex_waddr_i(ex_waddr), .ex_we_i(ex_we), .ex_rdata2_i(ex_rdata2),
    .ex_ov_i(ex_ov), .ex_hilo_we_i(ex_hilo_we), .ex_hi_i(ex_hi), .ex_lo_i(ex_lo),
    .ex_is_div_i(ex_is_div), .ex_mult_stall_i(ex_mult_stall),
    .div_ready_i(div_ready), .div_hi_i(div_hi), .div_lo_i(div_lo),
    .mem_stall_i(mem_stall), .flush_i(flush),
    .div_start_o(div_start), .ex_stall_o(ex_stall),
    .mem_valid_o(mem_valid), .mem_pc_o(mem_pc), .mem_aluout_o(mem_aluout),
    .mem_waddr_o(mem_waddr), .mem_we_o(mem_we), .mem_wdata_o(mem_wdata),
    .mem_ov_o(mem_ov), .mem_hilo_we_o(mem_hilo_we), .mem_hi_o(mem_hi), .mem_lo_o(mem_lo)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ex_idle();
    ex_valid = 1'b0; ex_pc = '0; ex_aluout = '0; ex_waddr = '0; ex_we = 1'b0;
    ex_rdata2 = '0; ex_ov = 1'b0; ex_hilo_we = '0; ex_hi = '0; ex_lo = '0; ex_is_div = 1'b0;
  endtask

  task automatic ex_instr(input logic [31:0] pc, input logic [31:0] alu, input logic [4:0] wa,
                          input logic we, input logic isdiv, input logic [1:0] hwe);
    ex_valid = 1'b1; ex_pc = pc; ex_aluout = alu; ex_waddr = wa; ex_we = we;
    ex_is_div = isdiv; ex_hilo_we = hwe; ex_rdata2 = '0; ex_ov = 1'b0;
    ex_hi = 32'hAAAA; ex_lo = 32'hBBBB;
  endtask

  initial begin
    rst = 1'b0;
    ex_idle();
    ex_mult_stall = 1'b0; div_ready = 1'b0; div_hi = '0; div_lo = '0;
    mem_stall = 1'b0; flush = 1'b0;

    #3;
    check("rst_valid", mem_valid, 0);
    check("rst_pc", mem_pc, 0);
    check("rst_stall", ex_stall, 0);
    check("rst_start", div_start, 0);
    #9 rst = 1'b1;
    tick();

    // ADD pass-through
    ex_instr(32'h100, 32'h1234, 5'd5, 1'b1, 1'b0, 2'b00);
    ex_rdata2 = 32'hCAFE;
    #1;
    check("add_stall_ex", ex_stall, 0);
    tick();
    check("add_valid", mem_valid, 1);
    check("add_alu", mem_aluout, 32'h1234);
    check("add_waddr", mem_waddr, 5);
    check("add_we", mem_we, 1);
    check("add_wdata", mem_wdata, 32'hCAFE);
    check("add_hi", mem_hi, 32'hAAAA);
    check("add_stall_mem", ex_stall, 0);
    ex_idle();
    tick();
    check("bub_valid", mem_valid, 0);
    check("bub_alu", mem_aluout, 0);

    // DIV, ready 33 cycles after start
    starts = 0; stalls = 0;
    ex_instr(32'h200, 32'h0, 5'd0, 1'b0, 1'b1, 2'b11);
    for (int c = 0; c <= 34; c++) begin
      div_ready = (c == 33);
      div_hi = (c == 33) ? 32'h3 : 32'h0;
      div_lo = (c == 33) ? 32'h7 : 32'h0;
      #1;
      starts += int'(div_start);
      stalls += int'(ex_stall);
      if (c == 0) check("div_start_c0", div_start, 1);
      if (c == 10) begin
        check("div_bub_valid", mem_valid, 0);
        check("div_bub_hwe", mem_hilo_we, 0);
      end
      if (c == 34) check("div_done_stall", ex_stall, 0);
      tick();
    end
    div_ready = 1'b0;
    check("div_starts", starts, 1);
    check("div_stalls", stalls, 34);
    check("div_valid", mem_valid, 1);
    check("div_pc", mem_pc, 32'h200);
    check("div_hi", mem_hi, 32'h3);
    check("div_lo", mem_lo, 32'h7);
    check("div_hwe", mem_hilo_we, 2'b11);

    // MEM stall held while the divide sits in DONE
    ex_instr(32'h300, 32'h55, 5'd7, 1'b1, 1'b0, 2'b00);
    tick();
    ex_instr(32'h400, 32'h0, 5'd0, 1'b0, 1'b1, 2'b11);
    mem_stall = 1'b1; starts = 0;
    for (int c = 0; c <= 6; c++) begin
      div_ready = (c == 2);
      div_hi = 32'h11; div_lo = 32'h22;
      if (c == 6) mem_stall = 1'b0;
      #1;
      starts += int'(div_start);
      if (c >= 3 && c <= 5) begin
        check("ds_stall", ex_stall, 1);
        check("ds_hold_pc", mem_pc, 32'h300);
      end
      if (c == 5) check("ds_hold_alu", mem_aluout, 32'h55);
      if (c == 6) check("ds_release", ex_stall, 0);
      tick();
    end
    div_ready = 1'b0;
    check("ds_starts", starts, 1);
    check("ds_pc", mem_pc, 32'h400);
    check("ds_hi", mem_hi, 32'h11);
    check("ds_lo", mem_lo, 32'h22);

    // Flush in BUSY cycle 10, new divide waits out the stale ready
    ex_instr(32'h500, 32'h0, 5'd0, 1'b0, 1'b1, 2'b11);
    starts = 0;
    for (int c = 0; c <= 19; c++) begin
      div_ready = (c == 15) || (c == 18);
      div_hi = (c == 15) ? 32'hDEAD : 32'h9;
      div_lo = (c == 15) ? 32'hBEEF : 32'h8;
      flush = (c == 10);
      if (c == 11) ex_instr(32'h600, 32'h0, 5'd0, 1'b0, 1'b1, 2'b11);
      #1;
      if (c == 0) check("fl_startA", div_start, 1);
      if (c >= 1) starts += int'(div_start);
      if (c == 11) check("fl_bubble", mem_valid, 0);
      if (c >= 11 && c <= 15) check("fl_abort_stall", ex_stall, 1);
      if (c == 16) check("fl_newstart", div_start, 1);
      if (c == 19) check("fl_done_stall", ex_stall, 0);
      tick();
    end
    div_ready = 1'b0; flush = 1'b0;
    check("fl_starts", starts, 1);
    check("fl_pc", mem_pc, 32'h600);
    check("fl_hi", mem_hi, 32'h9);
    check("fl_lo", mem_lo, 32'h8);

    // Flush and MEM stall together: flush wins
    ex_instr(32'h700, 32'h77, 5'd3, 1'b1, 1'b0, 2'b00);
    tick();
    check("fm_pre_pc", mem_pc, 32'h700);
    mem_stall = 1'b1; flush = 1'b1;
    #1;
    check("fm_stall", ex_stall, 1);
    tick();
    check("fm_valid", mem_valid, 0);
    check("fm_pc", mem_pc, 0);
    mem_stall = 1'b0; flush = 1'b0;

    // Multiplier stall for 4 cycles
    ex_instr(32'h900, 32'h99, 5'd2, 1'b1, 1'b0, 2'b00);
    tick();
    ex_instr(32'hA00, 32'hA5, 5'd9, 1'b1, 1'b0, 2'b01);
    ex_mult_stall = 1'b1; stalls = 0; bubs = 0;
    for (int c = 0; c < 4; c++) begin
      #1;
      stalls += int'(ex_stall);
      tick();
      bubs += int'(!mem_valid && !mem_we && mem_hilo_we == 2'b00);
    end
    check("ms_stalls", stalls, 4);
    check("ms_bubbles", bubs, 4);
    ex_mult_stall = 1'b0;
    #1;
    check("ms_release", ex_stall, 0);
    tick();
    check("ms_pc", mem_pc, 32'hA00);
    check("ms_we", mem_we, 1);
    check("ms_hwe", mem_hilo_we, 2'b01);

    // Asynchronous reset while BUSY
    ex_instr(32'hB00, 32'hBB, 5'd4, 1'b1, 1'b0, 2'b00);
    tick();
    ex_instr(32'hC00, 32'h0, 5'd0, 1'b0, 1'b1, 2'b11);
    mem_stall = 1'b1;
    #1;
    check("rs_start", div_start, 1);
    tick();
    tick();
    check("rs_held", mem_pc, 32'hB00);
    ex_idle();
    mem_stall = 1'b0;
    rst = 1'b0;
    #1;
    check("rs_valid", mem_valid, 0);
    check("rs_pc", mem_pc, 0);
    check("rs_alu", mem_aluout, 0);
    check("rs_we", mem_we, 0);
    check("rs_stall", ex_stall, 0);
    #2 rst = 1'b1;
    tick();
    ex_instr(32'hD00, 32'h0, 5'd0, 1'b0, 1'b1, 2'b11);
    div_hi = 32'h5; div_lo = 32'h6;
    #1;
    check("rs_restart", div_start, 1);
    tick();
    div_ready = 1'b1;
    tick();
    div_ready = 1'b0;
    #1;
    check("rs_done_stall", ex_stall, 0);
    tick();
    check("rs_pc_after", mem_pc, 32'hD00);
    check("rs_hi", mem_hi, 32'h5);
    check("rs_lo", mem_lo, 32'h6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
